// File: rtl/testbench_ls_pkt_pkg.sv
// testbench_ls_pkt_pkg: packetizer state encoding, header/trailer tags and field layout, word builders
package testbench_ls_pkt_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;
  localparam int TAG_LSB = 24;
  localparam int PKT_LSB = 8;
  localparam int CNT_LSB = 0;
  localparam int CSUM_LSB = 0;
  function automatic logic [31:0] mk_hdr(input logic [7:0] tag, input logic [15:0] num, input logic [7:0] n);
    mk_hdr = (32'(tag) << TAG_LSB) | (32'(num) << PKT_LSB) | (32'(n) << CNT_LSB);
  endfunction
  function automatic logic [31:0] mk_trl(input logic [7:0] tag, input logic [15:0] csum);
    mk_trl = (32'(tag) << TAG_LSB) | (32'(csum) << CSUM_LSB);
  endfunction
endpackage

// File: rtl/testbench_ls_st_outreg.sv
// testbench_ls_st_outreg: one-deep Avalon-ST output register; load/ld_data/ld_sop/ld_eop in, can_load out, out_valid/out_data/out_sop/out_eop toward sink gated by out_ready
module testbench_ls_st_outreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_sop,
  input  logic              ld_eop,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop
);
  assign can_load = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (can_load) begin
      out_valid <= load;
      if (load) begin
        out_data <= ld_data;
        out_sop  <= ld_sop;
        out_eop  <= ld_eop;
      end
    end
  end
endmodule

// File: rtl/testbench_ls_primitive_packetizer.sv
// testbench_ls_primitive_packetizer: frames N primitives (prim_valid/prim_data/prim_ready) into header+payload+checksum trailer on Avalon-ST out_*; prim_per_packet sets N (0 disables), pkt_count counts finished packets
module testbench_ls_primitive_packetizer #(
  parameter int         DATA_W  = 32,
  parameter logic [7:0] HDR_TAG = testbench_ls_pkt_pkg::HDR_TAG,
  parameter logic [7:0] TRL_TAG = testbench_ls_pkt_pkg::TRL_TAG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        prim_per_packet,
  input  logic              prim_valid,
  input  logic [DATA_W-1:0] prim_data,
  output logic              prim_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [15:0]       pkt_count
);
  import testbench_ls_pkt_pkg::*;
  state_t state, state_nx;
  logic [7:0] n_lat, rem;
  logic [15:0] pkt_num, csum;
  logic can_load, start, hdr_ld, acc, trl_ld, trl_done, load;
  logic [DATA_W-1:0] ld_data;
  assign start      = state == IDLE && prim_per_packet != 8'd0 && prim_valid;
  assign hdr_ld     = state == HEADER && can_load;
  assign prim_ready = state == PAYLOAD && can_load;
  assign acc        = prim_valid && prim_ready;
  // a registered eop word means the trailer is already waiting for the sink
  assign trl_ld     = state == TRAILER && !(out_valid && out_eop) && can_load;
  assign trl_done   = state == TRAILER && out_valid && out_eop && out_ready;
  assign load       = hdr_ld || acc || trl_ld;
  assign ld_data    = hdr_ld ? mk_hdr(HDR_TAG, pkt_num, n_lat) : trl_ld ? mk_trl(TRL_TAG, csum) : prim_data;
  assign pkt_count  = pkt_num;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? HEADER : IDLE;
      HEADER:  state_nx = can_load ? PAYLOAD : HEADER;
      PAYLOAD: state_nx = (acc && rem == 8'd1) ? TRAILER : PAYLOAD;
      TRAILER: state_nx = trl_done ? IDLE : TRAILER;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      n_lat   <= '0;
      rem     <= '0;
      pkt_num <= '0;
      csum    <= '0;
    end else begin
      state <= state_nx;
      if (start) n_lat <= prim_per_packet;
      if (hdr_ld) rem <= n_lat;
      if (acc) begin
        rem  <= rem - 8'd1;
        csum <= csum + prim_data[15:0];
      end
      if (trl_done) begin
        pkt_num <= pkt_num + 16'd1;
        csum    <= '0;
      end
    end
  end
  testbench_ls_st_outreg #(.DATA_W(DATA_W)) u_outreg (
    .clk(clk),
    .reset(reset),
    .load(load),
    .ld_data(ld_data),
    .ld_sop(hdr_ld),
    .ld_eop(trl_ld),
    .out_ready(out_ready),
    .can_load(can_load),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sop(out_sop),
    .out_eop(out_eop)
  );
endmodule

// File: tb/tb_testbench_ls_primitive_packetizer.sv
// tb_testbench_ls_primitive_packetizer: directed self-checking bench for the primitive packetizer
module tb_testbench_ls_primitive_packetizer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] prim_per_packet = 8'd0;
  logic prim_valid = 1'b0;
  logic [31:0] prim_data = '0;
  logic prim_ready, out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic out_ready = 1'b1;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0, idx = 0, k = 0, stalls = 0;
  bit bp = 1'b0, held = 1'b0;
  logic [33:0] held_w;
  logic [31:0] src[$];
  logic [33:0] cap[$], exp_q[$];
  logic [15:0] exp_pkt = 16'd0;
  always #5 clk = ~clk;
  testbench_ls_primitive_packetizer dut (
    .clk(clk),
    .reset(reset),
    .prim_per_packet(prim_per_packet),
    .prim_valid(prim_valid),
    .prim_data(prim_data),
    .prim_ready(prim_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_ready(out_ready),
    .pkt_count(pkt_count)
  );
  function automatic logic [33:0] hdr(input logic [15:0] num, input logic [7:0] n);
    hdr = {2'b10, 8'hA5, num, n};
  endfunction
  function automatic logic [33:0] trl(input logic [15:0] cs);
    trl = {2'b01, 8'h5A, 8'h00, cs};
  endfunction
  function automatic logic [33:0] pay(input logic [31:0] d);
    pay = {2'b00, d};
  endfunction
  task automatic cycle();
    @(negedge clk);
    out_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
    k++;
    prim_valid = idx < src.size();
    prim_data = prim_valid ? src[idx] : '0;
    #1;
    if (held) begin
      checks++;
      stalls++;
      if (!out_valid || {out_sop, out_eop, out_data} !== held_w) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b word=%h required v=1 word=%h", out_valid, {out_sop, out_eop, out_data}, held_w);
      end
    end
    held = out_valid && !out_ready;
    held_w = {out_sop, out_eop, out_data};
    if (out_valid && out_ready) cap.push_back({out_sop, out_eop, out_data});
    if (prim_valid && prim_ready) idx++;
  endtask
  task automatic run(input int target);
    int g = 0;
    while (cap.size() < target && g < 400) begin
      cycle();
      g++;
    end
    if (cap.size() < target) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d beats required %0d", cap.size(), target);
    end
  endtask
  task automatic start_pkt(input logic [7:0] n);
    cap.delete();
    exp_q.delete();
    idx = 0;
    prim_per_packet = n;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_sop !== 1'b0) begin errors++; $display("FAIL reset_out_sop: got %b required 0", out_sop); end
    if (out_eop !== 1'b0) begin errors++; $display("FAIL reset_out_eop: got %b required 0", out_eop); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    if (prim_ready !== 1'b0) begin errors++; $display("FAIL reset_prim_ready: got %b required 0", prim_ready); end
    if (pkt_count !== 16'h0) begin errors++; $display("FAIL reset_pkt_count: got %h required 0", pkt_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic();
    start_pkt(8'd3);
    src = '{32'h1, 32'h2, 32'h3};
    exp_q = '{hdr(16'h0, 8'd3), pay(32'h1), pay(32'h2), pay(32'h3), trl(16'h0006)};
    run(5);
    foreach (exp_q[i]) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h required %h", i, cap[i], exp_q[i]); end
    end
    cycle();
    checks++;
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d required 1", pkt_count); end
    exp_pkt = 16'd1;
  endtask
  task automatic test_disabled();
    start_pkt(8'd0);
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(32'h100 + i);
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks += 2;
      if (prim_ready !== 1'b0) begin errors++; $display("FAIL disabled_prim_ready cyc%0d: got %b required 0", i, prim_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL disabled_out_valid cyc%0d: got %b required 0", i, out_valid); end
    end
    src.delete();
    cycle();
  endtask
  task automatic test_backpressure();
    start_pkt(8'd4);
    src = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_q = '{hdr(exp_pkt, 8'd4), pay(32'h11), pay(32'h22), pay(32'h33), pay(32'h44), trl(16'h00AA)};
    bp = 1'b1;
    stalls = 0;
    run(6);
    bp = 1'b0;
    checks++;
    if (cap.size() != 6) begin errors++; $display("FAIL bp_beat_count: got %0d required 6", cap.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, cap[i], exp_q[i]); end
    end
    checks++;
    if (stalls == 0) begin errors++; $display("FAIL bp_no_stall: got 0 stalled cycles required >0"); end
    repeat (2) cycle();
    exp_pkt++;
    checks++;
    if (pkt_count !== exp_pkt) begin errors++; $display("FAIL bp_pkt_count: got %0d required %0d", pkt_count, exp_pkt); end
  endtask
  task automatic test_reset_mid_packet();
    start_pkt(8'd3);
    src = '{32'h7, 32'h8, 32'h9};
    run(2);
    @(negedge clk);
    reset = 1'b1;
    prim_valid = 1'b0;
    @(negedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b required 0", out_valid); end
    if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_mid_pkt_count: got %0d required 0", pkt_count); end
    if (prim_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_prim_ready: got %b required 0", prim_ready); end
    reset = 1'b0;
    held = 1'b0;
    exp_pkt = 16'd0;
    start_pkt(8'd3);
    src = '{32'h7, 32'h8, 32'h9};
    exp_q = '{hdr(16'h0, 8'd3), pay(32'h7), pay(32'h8), pay(32'h9), trl(16'h0018)};
    run(5);
    foreach (exp_q[i]) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_beat%0d: got %h required %h", i, cap[i], exp_q[i]); end
    end
    cycle();
    exp_pkt = 16'd1;
  endtask
  task automatic test_wrap_config();
    start_pkt(8'd2);
    src = '{32'h0000FFFF, 32'h00000002, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    exp_q = '{hdr(exp_pkt, 8'd2), pay(32'h0000FFFF), pay(32'h2), trl(16'h0001),
              hdr(exp_pkt + 16'd1, 8'd5), pay(32'h1), pay(32'h2), pay(32'h3), pay(32'h4), pay(32'h5), trl(16'h000F)};
    run(1);
    prim_per_packet = 8'd5;
    run(11);
    foreach (exp_q[i]) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_beat%0d: got %h required %h", i, cap[i], exp_q[i]); end
    end
    cycle();
    exp_pkt += 16'd2;
    checks++;
    if (pkt_count !== exp_pkt) begin errors++; $display("FAIL wrap_pkt_count: got %0d required %0d", pkt_count, exp_pkt); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
